bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master, multi-slave arbiter and router for the serial memory bus. It grants one master at a time and holds the grant for that master's whole transaction. While a grant is held, it routes the master's serial strobes to the slave that master selected, and routes that slave's handshake and read-data lines back. It sits between the bus masters and the BRAM slave instances and enforces a bus-hold timeout.

## Interface
- `NS`, 3: number of slaves.
- `SSEL_W`, 2: width of the slave-select field. Must satisfy 2^SSEL_W ≥ NS.
- `TIMEOUT`, 64: maximum number of BUSY cycles before the grant is forcibly revoked. Must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `m_req` in 2: bus request, one bit per master. A master holds it high for its whole transaction.
- `m_ssel` in 2*SSEL_W: target slave per master. Master i uses bits [i*SSEL_W +: SSEL_W]. Sampled at grant.
- `m_valid`, `m_wren`, `m_addr`, `m_data` in 2 each: per-master serial bus strobes.
- `m_grant` out 2: registered, one-hot or zero.
- `m_err` out 2: registered one-cycle error pulse, per master.
- `m_ready`, `m_rvalid`, `m_rdata` out 2 each: slave responses routed back to the granted master. Zero for the non-granted master.
- `s_valid` out NS: valid strobe, driven only to the selected slave. All other bits are 0.
- `s_wren`, `s_addr`, `s_data` out 1 each: broadcast from the granted master. 0 when no grant is held.
- `s_ready`, `s_rvalid`, `s_rdata` in NS each: per-slave responses.

## Operation
- The FSM has four states: IDLE, BUSY, RELEASE, ERRWAIT (encodings 0–3).
- IDLE:
  - Ignore any requester whose mask bit is set.
  - Choose a winner by round-robin. Priority goes to the master not granted last; `last` resets to 1, so master 0 wins first.
  - If the winner's `m_ssel` is < NS: latch the select into `sel_q`, set `m_grant[winner]`, clear the timeout counter, and go to BUSY.
  - If the winner's `m_ssel` is ≥ NS: pulse `m_err[winner]`, set `mask[winner]`, grant nothing, and go to ERRWAIT.
  - The loser of a simultaneous request stays pending. It is served at the next IDLE.
- BUSY:
  - Routing is combinational from the registered grant and `sel_q`: `s_valid[sel_q] = m_valid[g]`; `s_wren`, `s_addr`, `s_data` come from master g.
  - `m_ready[g] = s_ready[sel_q]`, `m_rvalid[g] = s_rvalid[sel_q]`, `m_rdata[g] = s_rdata[sel_q]`.
  - The counter increments every BUSY cycle.
- Leaving BUSY:
  - If `m_req[g]` is 0: clear the grant, update `last = g`, and go to RELEASE.
  - Else, if the counter has reached TIMEOUT−1: clear the grant, pulse `m_err[g]`, set `mask[g]`, update `last`, and go to RELEASE.
  - A request drop takes precedence over a timeout in the same cycle. No error is raised in that case.
- RELEASE lasts exactly one cycle with all slave strobes at 0, which lets the slave FSM return to IDLE. Then go to IDLE.
- ERRWAIT lasts one cycle, then goes to IDLE.
- Masks: `mask[i]` clears in any cycle where `m_req[i]` is 0. A timed-out or erred master must therefore drop `m_req` before it can be granted again.
- Masters never see another master's slave responses.
- Counter width is $clog2(TIMEOUT). There is no wrap: BUSY is exited at TIMEOUT−1.

## Timing
- Reset values: state IDLE, `m_grant` 0, `m_err` 0, `mask` 0, `last` 1, `sel_q` 0, counter 0. All routed outputs are 0 because no grant is held.
- Request to grant latency is one cycle. `m_req` sampled high in IDLE at edge t gives `m_grant` high after edge t.
- The master may drive `m_valid` from the first cycle it sees `m_grant` = 1.
- `m_req` low in BUSY at edge t gives `m_grant` = 0 after edge t. The next grant appears no earlier than edge t+2 (one RELEASE cycle, then IDLE).
- Back-to-back throughput is at least 2 dead cycles between grants.
- The maximum grant length is TIMEOUT cycles.
- Reset mid-transaction drops the grant and all slave strobes on the next edge. Slave state is not reset by this block.
- A change in `m_ssel` during BUSY is ignored.

## Structure
- Package `bus_pkg`:
  - state localparams: IDLE, BUSY, RELEASE, ERRWAIT;
  - master count (2);
  - default `SSEL_W`, `NS`, `TIMEOUT`.
- One sub-module, `rr_arb2`: combinational 2-way round-robin pick.
  - Inputs: request vector, `last`.
  - Outputs: one-hot winner, valid.
- The FSM, counter, masks and routing muxes live in `bus_arbiter`.

## Test plan
- Master 0 requests alone with ssel = 1 and writes addr 0x005, data 0xA5, then drops req. Required: grant 1 cycle later, only `s_valid[1]` toggles, and a RELEASE gap of one cycle. Master 1 then reads 0x005 from slave 1 and receives 0xA5 on `m_rdata[1]`.
- Both masters request in the same cycle after reset. Required: master 0 is granted first. Master 1 is granted 2 cycles after master 0 drops req. A repeat of the simultaneous request grants master 1 first.
- Master 1 requests with ssel = 3 (NS = 3). Required: `m_err[1]` pulses for one cycle and no grant is given. Master 1 keeping req high gets no grant. After master 1 drops and re-asserts req with ssel = 0, it is granted.
- Master 0 holds req for 100 cycles with TIMEOUT = 64. Required: the grant lasts exactly 64 cycles, `m_err[0]` pulses as it falls, and master 1 (pending) is granted 2 cycles later.
- `rst` is asserted in the middle of the serial address phase of a granted transaction. Required: `m_grant` = 0, all `s_valid` = 0, and `m_err` = 0 on the next edge. The state is IDLE and master 0 has priority again.
- Master 1 drops req in the same cycle the counter reaches TIMEOUT−1. Required: normal release and no `m_err` pulse.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default sizing for the two-master serial memory bus arbiter.
package bus_pkg;

  // Arbiter FSM states; encodings are fixed (0..3).
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2,
    ERRWAIT = 2'd3
  } busState_t;

  localparam int unsigned NUM_MASTERS = 2;

  localparam int unsigned DEF_NS      = 3;
  localparam int unsigned DEF_SSEL_W  = 2;
  localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side and slave-side signals of the arbitrated serial memory bus.
// slave : the arbiter's view (receives master strobes, drives slave strobes).
// master: the environment's view (bus masters and BRAM slaves).
interface bus_arbiter_if
  import bus_pkg::*;
#(
  parameter int unsigned NS     = DEF_NS,
  parameter int unsigned SSEL_W = DEF_SSEL_W
) ();

  logic [NUM_MASTERS-1:0]        m_req;
  logic [NUM_MASTERS*SSEL_W-1:0] m_ssel;
  logic [NUM_MASTERS-1:0]        m_valid;
  logic [NUM_MASTERS-1:0]        m_wren;
  logic [NUM_MASTERS-1:0]        m_addr;
  logic [NUM_MASTERS-1:0]        m_data;
  logic [NUM_MASTERS-1:0]        m_grant;
  logic [NUM_MASTERS-1:0]        m_err;
  logic [NUM_MASTERS-1:0]        m_ready;
  logic [NUM_MASTERS-1:0]        m_rvalid;
  logic [NUM_MASTERS-1:0]        m_rdata;

  logic [NS-1:0]                 s_valid;
  logic                          s_wren;
  logic                          s_addr;
  logic                          s_data;
  logic [NS-1:0]                 s_ready;
  logic [NS-1:0]                 s_rvalid;
  logic [NS-1:0]                 s_rdata;

  modport slave (
    input  m_req, m_ssel, m_valid, m_wren, m_addr, m_data,
    input  s_ready, s_rvalid, s_rdata,
    output m_grant, m_err, m_ready, m_rvalid, m_rdata,
    output s_valid, s_wren, s_addr, s_data
  );

  modport master (
    output m_req, m_ssel, m_valid, m_wren, m_addr, m_data,
    output s_ready, s_rvalid, s_rdata,
    input  m_grant, m_err, m_ready, m_rvalid, m_rdata,
    input  s_valid, s_wren, s_addr, s_data
  );

endinterface

// File: rtl/bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: the master not granted last wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner_c,
  output logic       valid_c
);

  // Priority flips with the index of the previously granted master.
  always_comb begin
    winner_c = 2'b00;
    if (last) begin
      if (req[0])      winner_c = 2'b01;
      else if (req[1]) winner_c = 2'b10;
    end else begin
      if (req[1])      winner_c = 2'b10;
      else if (req[0]) winner_c = 2'b01;
    end
  end

  assign valid_c = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter/router for the serial memory bus with bus-hold timeout.
// One grant at a time, held for the whole transaction; strobes go to the slave
// latched at grant time and that slave's responses come back to the owner only.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NS      = DEF_NS,
  parameter int unsigned SSEL_W  = DEF_SSEL_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  busState_t                  state, stateNext;
  logic [NUM_MASTERS-1:0]     grantQ, grantNext;
  logic [NUM_MASTERS-1:0]     errQ, errNext;
  logic [NUM_MASTERS-1:0]     maskQ, maskNext;
  logic                       lastQ, lastNext;
  logic [SSEL_W-1:0]          selQ, selNext;
  logic [CNT_W-1:0]           cnt, cntNext;

  logic [NUM_MASTERS-1:0]     eligible;
  logic [NUM_MASTERS-1:0]     winC;
  logic                       winValidC;
  logic                       winIdx;
  logic [SSEL_W-1:0]          winSel;
  logic                       selOk;
  logic                       gIdx;
  logic                       reqG;
  logic                       timeoutHit;

  logic [NS-1:0]              sValidC;
  logic                       sWrenC, sAddrC, sDataC;
  logic [NUM_MASTERS-1:0]     mReadyC, mRvalidC, mRdataC;

  // Masked requesters never compete until they drop their request.
  assign eligible = bus.m_req & ~maskQ;

  rr_arb2 u_rr (
    .req      (eligible),
    .last     (lastQ),
    .winner_c (winC),
    .valid_c  (winValidC)
  );

  assign winIdx     = winC[1];
  assign winSel     = winIdx ? bus.m_ssel[2*SSEL_W-1:SSEL_W] : bus.m_ssel[SSEL_W-1:0];
  assign selOk      = (32'(winSel) < NS);
  assign gIdx       = grantQ[1];
  assign reqG       = bus.m_req[gIdx];
  assign timeoutHit = (cnt == CNT_W'(TIMEOUT - 1));

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grantQ <= '0;
      errQ   <= '0;
      maskQ  <= '0;
      lastQ  <= 1'b1;
      selQ   <= '0;
      cnt    <= '0;
    end else begin
      state  <= stateNext;
      grantQ <= grantNext;
      errQ   <= errNext;
      maskQ  <= maskNext;
      lastQ  <= lastNext;
      selQ   <= selNext;
      cnt    <= cntNext;
    end
  end

  // Next-state: arbitration in IDLE, hold/timeout in BUSY, single-cycle gaps after.
  always_comb begin
    stateNext = state;
    grantNext = grantQ;
    errNext   = '0;
    maskNext  = maskQ & bus.m_req;
    lastNext  = lastQ;
    selNext   = selQ;
    cntNext   = cnt;

    case (state)
      IDLE: begin
        if (winValidC) begin
          if (selOk) begin
            selNext   = winSel;
            grantNext = winC;
            cntNext   = '0;
            stateNext = BUSY;
          end else begin
            errNext   = winC;
            maskNext  = maskNext | winC;
            stateNext = ERRWAIT;
          end
        end
      end

      BUSY: begin
        cntNext = cnt + CNT_W'(1);
        // A dropped request wins over a simultaneous timeout and raises no error.
        if (!reqG) begin
          grantNext = '0;
          lastNext  = gIdx;
          stateNext = RELEASE;
        end else if (timeoutHit) begin
          grantNext = '0;
          errNext   = grantQ;
          maskNext  = maskNext | grantQ;
          lastNext  = gIdx;
          stateNext = RELEASE;
        end
      end

      RELEASE: stateNext = IDLE;

      ERRWAIT: stateNext = IDLE;

      default: stateNext = IDLE;
    endcase
  end

  // Routing muxes driven from the registered grant and latched select.
  always_comb begin
    sValidC  = '0;
    sWrenC   = 1'b0;
    sAddrC   = 1'b0;
    sDataC   = 1'b0;
    mReadyC  = '0;
    mRvalidC = '0;
    mRdataC  = '0;
    if (|grantQ) begin
      sWrenC = bus.m_wren[gIdx];
      sAddrC = bus.m_addr[gIdx];
      sDataC = bus.m_data[gIdx];
      for (int i = 0; i < int'(NS); i++) begin
        if (selQ == SSEL_W'(i)) begin
          sValidC[i]     = bus.m_valid[gIdx];
          mReadyC[gIdx]  = bus.s_ready[i];
          mRvalidC[gIdx] = bus.s_rvalid[i];
          mRdataC[gIdx]  = bus.s_rdata[i];
        end
      end
    end
  end

  assign bus.m_grant  = grantQ;
  assign bus.m_err    = errQ;
  assign bus.m_ready  = mReadyC;
  assign bus.m_rvalid = mRvalidC;
  assign bus.m_rdata  = mRdataC;
  assign bus.s_valid  = sValidC;
  assign bus.s_wren   = sWrenC;
  assign bus.s_addr   = sAddrC;
  assign bus.s_data   = sDataC;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant latency, routing, round-robin,
// bad select, timeout, reset mid-transaction and drop-at-timeout.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int unsigned NS      = 3;
  localparam int unsigned SSEL_W  = 2;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nTests = 0;
  int   nFail  = 0;

  bus_arbiter_if #(.NS(NS), .SSEL_W(SSEL_W)) bif ();

  bus_arbiter #(.NS(NS), .SSEL_W(SSEL_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.m_req    = '0;
    bif.m_ssel   = '0;
    bif.m_valid  = '0;
    bif.m_wren   = '0;
    bif.m_addr   = '0;
    bif.m_data   = '0;
    bif.s_ready  = '0;
    bif.s_rvalid = '0;
    bif.s_rdata  = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bif.m_valid = 2'b11; bif.m_wren = 2'b11; bif.m_addr = 2'b11; bif.m_data = 2'b11;
    bif.s_ready = 3'b111; bif.s_rvalid = 3'b111; bif.s_rdata = 3'b111;
    rst = 1'b1;
    tick(); tick();
    nTests++;
    if ({bif.m_grant, bif.m_err} !== 4'b0000) begin
      nFail++; $display("FAIL reset_grant_err: got %b want 0000", {bif.m_grant, bif.m_err});
    end
    nTests++;
    if ({bif.s_valid, bif.s_wren, bif.s_addr, bif.s_data} !== 6'b0) begin
      nFail++; $display("FAIL reset_slave_strobes: got %b want 000000",
                        {bif.s_valid, bif.s_wren, bif.s_addr, bif.s_data});
    end
    nTests++;
    if ({bif.m_ready, bif.m_rvalid, bif.m_rdata} !== 6'b0) begin
      nFail++; $display("FAIL reset_master_resp: got %b want 000000",
                        {bif.m_ready, bif.m_rvalid, bif.m_rdata});
    end
    rst = 1'b0;
    clear_inputs();
    tick();
    nTests++;
    if (bif.m_grant !== 2'b00) begin
      nFail++; $display("FAIL reset_idle_nogrant: got %b want 00", bif.m_grant);
    end
  endtask

  task automatic test_write_read();
    logic [11:0] wrAddr = 12'h005;
    logic [7:0]  wrData = 8'hA5;
    logic [11:0] capA = '0;
    logic [7:0]  capD = '0;
    logic [7:0]  capR = '0;
    logic [11:0] memAddr;
    logic [7:0]  memData;
    logic [7:0]  rdByte;
    bif.m_ssel = {2'd0, 2'd1};
    bif.m_req  = 2'b01;
    #1;
    nTests++;
    if (bif.m_grant !== 2'b00) begin
      nFail++; $display("FAIL wr_grant_before_edge: got %b want 00", bif.m_grant);
    end
    tick();
    nTests++;
    if (bif.m_grant !== 2'b01) begin
      nFail++; $display("FAIL wr_grant_latency: got %b want 01", bif.m_grant);
    end
    bif.m_wren  = 2'b01;
    bif.s_ready = 3'b010;
    for (int i = 0; i < 12; i++) begin
      bif.m_valid   = 2'b01;
      bif.m_addr[0] = wrAddr[11-i];
      #1;
      nTests++;
      if ({bif.s_valid, bif.s_wren, bif.m_ready} !== 6'b010_1_01) begin
        nFail++; $display("FAIL wr_addr_route bit%0d: got %b want 010101", i,
                          {bif.s_valid, bif.s_wren, bif.m_ready});
      end
      capA = {capA[10:0], bif.s_addr};
      tick();
    end
    bif.m_addr = '0;
    for (int i = 0; i < 8; i++) begin
      bif.m_data[0] = wrData[7-i];
      #1;
      nTests++;
      if (bif.s_valid !== 3'b010) begin
        nFail++; $display("FAIL wr_data_valid bit%0d: got %b want 010", i, bif.s_valid);
      end
      capD = {capD[6:0], bif.s_data};
      tick();
    end
    nTests++;
    if ({capA, capD} !== {12'h005, 8'hA5}) begin
      nFail++; $display("FAIL wr_slave_capture: got %h/%h want 005/a5", capA, capD);
    end
    memAddr = capA;
    memData = capD;
    bif.m_valid = '0; bif.m_wren = '0; bif.m_data = '0; bif.s_ready = '0;
    bif.m_ssel  = {2'd1, 2'd1};
    bif.m_req   = 2'b10;
    #1;
    nTests++;
    if (bif.s_valid !== 3'b000) begin
      nFail++; $display("FAIL wr_valid_idle: got %b want 000", bif.s_valid);
    end
    tick();
    nTests++;
    if ({bif.m_grant, bif.s_valid} !== 5'b00_000) begin
      nFail++; $display("FAIL wr_release: got %b want 00000", {bif.m_grant, bif.s_valid});
    end
    tick();
    nTests++;
    if (bif.m_grant !== 2'b00) begin
      nFail++; $display("FAIL rd_gap: got %b want 00", bif.m_grant);
    end
    tick();
    nTests++;
    if (bif.m_grant !== 2'b10) begin
      nFail++; $display("FAIL rd_grant: got %b want 10", bif.m_grant);
    end
    capA = '0;
    for (int i = 0; i < 12; i++) begin
      bif.m_valid   = 2'b10;
      bif.m_addr[1] = wrAddr[11-i];
      #1;
      nTests++;
      if ({bif.s_valid, bif.s_wren} !== 4'b010_0) begin
        nFail++; $display("FAIL rd_addr_route bit%0d: got %b want 0100", i, {bif.s_valid, bif.s_wren});
      end
      capA = {capA[10:0], bif.s_addr};
      tick();
    end
    bif.m_valid = '0; bif.m_addr = '0;
    rdByte = (capA == memAddr) ? memData : 8'h00;
    for (int i = 0; i < 8; i++) begin
      bif.s_rvalid = 3'b010;
      bif.s_rdata  = {1'b1, rdByte[7-i], 1'b1};
      #1;
      nTests++;
      if ({bif.m_rvalid, bif.m_rdata[0]} !== 3'b10_0) begin
        nFail++; $display("FAIL rd_resp_route bit%0d: got %b want 100", i, {bif.m_rvalid, bif.m_rdata[0]});
      end
      capR = {capR[6:0], bif.m_rdata[1]};
      tick();
    end
    bif.s_rvalid = '0; bif.s_rdata = '0;
    nTests++;
    if (capR !== 8'hA5) begin
      nFail++; $display("FAIL rd_data: got %h want a5", capR);
    end
    bif.m_req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_simultaneous();
    rst = 1'b1; tick(); rst = 1'b0;
    bif.m_ssel = {2'd2, 2'd0};
    bif.m_req  = 2'b11;
    tick();
    nTests++;
    if (bif.m_grant !== 2'b01) begin
      nFail++; $display("FAIL sim_first: got %b want 01", bif.m_grant);
    end
    tick();
    bif.m_req = 2'b10;
    tick();
    nTests++;
    if (bif.m_grant !== 2'b00) begin
      nFail++; $display("FAIL sim_release: got %b want 00", bif.m_grant);
    end
    tick();
    nTests++;
    if (bif.m_grant !== 2'b00) begin
      nFail++; $display("FAIL sim_gap: got %b want 00", bif.m_grant);
    end
    tick();
    nTests++;
    if (bif.m_grant !== 2'b10) begin
      nFail++; $display("FAIL sim_second: got %b want 10", bif.m_grant);
    end
    bif.m_req = 2'b00;
    tick(); tick();
    bif.m_req = 2'b01;
    tick();
    bif.m_req = 2'b00;
    tick(); tick();
    bif.m_req = 2'b11;
    tick();
    bif.m_valid = 2'b10;
    #1;
    nTests++;
    if ({bif.m_grant, bif.s_valid} !== 5'b10_100) begin
      nFail++; $display("FAIL sim_repeat_m1: got %b want 10100", {bif.m_grant, bif.s_valid});
    end
    bif.m_valid = '0;
    bif.m_req   = 2'b01;
    tick(); tick(); tick();
    nTests++;
    if (bif.m_grant !== 2'b01) begin
      nFail++; $display("FAIL sim_repeat_m0: got %b want 01", bif.m_grant);
    end
    bif.m_req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_bad_ssel();
    bif.m_ssel = {2'd3, 2'd0};
    bif.m_req  = 2'b10;
    tick();
    nTests++;
    if ({bif.m_err, bif.m_grant} !== 4'b10_00) begin
      nFail++; $display("FAIL bad_err_pulse: got %b want 1000", {bif.m_err, bif.m_grant});
    end
    tick();
    nTests++;
    if ({bif.m_err, bif.m_grant} !== 4'b00_00) begin
      nFail++; $display("FAIL bad_err_end: got %b want 0000", {bif.m_err, bif.m_grant});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      nTests++;
      if ({bif.m_err, bif.m_grant} !== 4'b00_00) begin
        nFail++; $display("FAIL bad_masked cyc%0d: got %b want 0000", i, {bif.m_err, bif.m_grant});
      end
    end
    bif.m_req = 2'b00;
    tick();
    bif.m_ssel = {2'd0, 2'd0};
    bif.m_req  = 2'b10;
    tick();
    nTests++;
    if (bif.m_grant !== 2'b10) begin
      nFail++; $display("FAIL bad_regrant: got %b want 10", bif.m_grant);
    end
    bif.m_req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int held = 1;
    bif.m_ssel = {2'd2, 2'd0};
    bif.m_req  = 2'b01;
    tick();
    bif.m_req = 2'b11;
    for (int k = 1; k < 64; k++) begin
      if ({bif.m_grant, bif.m_err} === 4'b01_00) held++;
      tick();
    end
    nTests++;
    if (held !== 64 || bif.m_grant !== 2'b01) begin
      nFail++; $display("FAIL to_grant_length: got %0d cycles (grant %b) want 64 (01)", held, bif.m_grant);
    end
    tick();
    nTests++;
    if ({bif.m_grant, bif.m_err} !== 4'b00_01) begin
      nFail++; $display("FAIL to_revoke: got %b want 0001", {bif.m_grant, bif.m_err});
    end
    tick();
    nTests++;
    if ({bif.m_grant, bif.m_err} !== 4'b00_00) begin
      nFail++; $display("FAIL to_gap: got %b want 0000", {bif.m_grant, bif.m_err});
    end
    tick();
    nTests++;
    if (bif.m_grant !== 2'b10) begin
      nFail++; $display("FAIL to_pending_m1: got %b want 10", bif.m_grant);
    end
    bif.m_req = 2'b10;
    tick();
    bif.m_req = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_drop_at_timeout();
    bif.m_ssel = {2'd1, 2'd0};
    bif.m_req  = 2'b10;
    tick();
    for (int k = 1; k < 64; k++) tick();
    nTests++;
    if (bif.m_grant !== 2'b10) begin
      nFail++; $display("FAIL drop_still_held: got %b want 10", bif.m_grant);
    end
    bif.m_req = 2'b00;
    tick();
    nTests++;
    if ({bif.m_grant, bif.m_err} !== 4'b00_00) begin
      nFail++; $display("FAIL drop_no_err: got %b want 0000", {bif.m_grant, bif.m_err});
    end
    tick();
    nTests++;
    if (bif.m_err !== 2'b00) begin
      nFail++; $display("FAIL drop_no_err_late: got %b want 00", bif.m_err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bif.m_ssel = {2'd0, 2'd0};
    bif.m_req  = 2'b01;
    tick();
    bif.m_req = 2'b00;
    tick(); tick();
    bif.m_req = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) begin
      bif.m_valid   = 2'b01;
      bif.m_addr[0] = i[0];
      #1;
      nTests++;
      if ({bif.m_grant, bif.s_valid} !== 5'b01_001) begin
        nFail++; $display("FAIL rstmid_route bit%0d: got %b want 01001", i, {bif.m_grant, bif.s_valid});
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nTests++;
    if ({bif.m_grant, bif.s_valid, bif.m_err} !== 7'b0) begin
      nFail++; $display("FAIL rstmid_drop: got %b want 0000000", {bif.m_grant, bif.s_valid, bif.m_err});
    end
    bif.m_req = 2'b11;
    tick();
    nTests++;
    if (bif.m_grant !== 2'b01) begin
      nFail++; $display("FAIL rstmid_priority: got %b want 01", bif.m_grant);
    end
    bif.m_req   = 2'b00;
    bif.m_valid = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_bad_ssel();
    test_timeout();
    test_drop_at_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
